// File: rtl/nn_pkg.sv
// Shared types, default sizes and the result saturation helper for the inference sequencer.
package nn_pkg;
    localparam int DEF_NUM_INPUTS  = 784;
    localparam int DEF_NUM_OUTPUTS = 10;
    localparam int DEF_DATA_W      = 16;
    localparam int DEF_RES_W       = 17;

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, WRITE, DONE} calc_state_t;

    // Clamps a sign-extended value into the signed range of a res_w-bit result.
    function automatic logic signed [63:0] sat(input logic signed [63:0] value, input int res_w);
        logic signed [63:0] max_val;
        logic signed [63:0] min_val;
        max_val = (64'sd1 <<< (res_w - 1)) - 64'sd1;
        min_val = -(64'sd1 <<< (res_w - 1));
        if (value > max_val) return max_val;
        if (value < min_val) return min_val;
        return value;
    endfunction
endpackage

// File: rtl/mac_unit.sv
// Signed multiply-accumulate with a wide accumulator; scaling and saturation happen only on the way out.
module mac_unit import nn_pkg::*; #(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ACC_W     = 40,
    parameter int FRAC_BITS = 15,
    parameter int RES_W     = DEF_RES_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     valid,
    input  logic signed [DATA_W-1:0] pixel,
    input  logic signed [DATA_W-1:0] weight,
    output logic signed [RES_W-1:0]  result
);
    logic signed [2*DATA_W-1:0] product;
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    shifted;
    logic signed [63:0]         clamped;
    logic                       unused_hi;

    assign product = pixel * weight;

    // Clear wins over accumulate so a neuron never inherits a stale partial sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            acc <= '0;
        else if (clear)
            acc <= '0;
        else if (valid)
            acc <= acc + {{(ACC_W-2*DATA_W){product[2*DATA_W-1]}}, product};
    end

    assign shifted   = acc >>> FRAC_BITS;
    assign clamped   = sat({{(64-ACC_W){shifted[ACC_W-1]}}, shifted}, RES_W);
    assign result    = clamped[RES_W-1:0];
    assign unused_hi = ^clamped[63:RES_W];
endmodule

// File: rtl/calc_controller.sv
// Walks every output neuron over all input pixels, issuing paired pixel/weight reads into the MAC
// and writing one saturated result per neuron.
module calc_controller import nn_pkg::*; #(
    parameter int NUM_INPUTS  = DEF_NUM_INPUTS,
    parameter int NUM_OUTPUTS = DEF_NUM_OUTPUTS,
    parameter int PADDR_W     = 11,
    parameter int WADDR_W     = 13,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ACC_W       = 40,
    parameter int FRAC_BITS   = 15,
    parameter int RES_W       = DEF_RES_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_calc,
    input  logic               abort,
    input  logic [DATA_W-1:0]  pixel_q,
    input  logic [DATA_W-1:0]  weight_q,
    output logic [PADDR_W-1:0] pixel_address,
    output logic [WADDR_W-1:0] weight_address,
    output logic               mem_rd_en,
    output logic               busy,
    output logic               result_we,
    output logic [3:0]         output_address,
    output logic [RES_W-1:0]   result_output,
    output logic               done_calc,
    output logic               results_ready
);
    calc_state_t        state;
    logic [WADDR_W-1:0] base;
    logic [3:0]         neuron;
    logic               pipe_valid;
    logic               abort_run;
    logic               acc_clear;

    assign abort_run = abort && (state != IDLE);
    assign acc_clear = abort_run || (state == WRITE) || (state == IDLE && start_calc);

    // Read data lags the address by one cycle, so the product is valid one cycle after the strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pipe_valid <= 1'b0;
        else
            pipe_valid <= abort_run ? 1'b0 : mem_rd_en;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            pixel_address  <= '0;
            weight_address <= '0;
            mem_rd_en      <= 1'b0;
            busy           <= 1'b0;
            result_we      <= 1'b0;
            output_address <= '0;
            done_calc      <= 1'b0;
            results_ready  <= 1'b0;
            base           <= '0;
            neuron         <= '0;
        end else if (abort_run) begin
            state         <= IDLE;
            mem_rd_en     <= 1'b0;
            busy          <= 1'b0;
            result_we     <= 1'b0;
            done_calc     <= 1'b0;
            results_ready <= 1'b0;
        end else begin
            result_we <= 1'b0;
            done_calc <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_calc) begin
                        state          <= RUN;
                        busy           <= 1'b1;
                        mem_rd_en      <= 1'b1;
                        pixel_address  <= '0;
                        weight_address <= '0;
                        base           <= '0;
                        neuron         <= '0;
                        results_ready  <= 1'b0;
                    end
                end
                RUN: begin
                    if (pixel_address == PADDR_W'(NUM_INPUTS - 1)) begin
                        state     <= DRAIN;
                        mem_rd_en <= 1'b0;
                    end else begin
                        pixel_address  <= pixel_address + PADDR_W'(1);
                        weight_address <= weight_address + WADDR_W'(1);
                    end
                end
                DRAIN: begin
                    state          <= WRITE;
                    result_we      <= 1'b1;
                    output_address <= neuron;
                end
                WRITE: begin
                    if (neuron == 4'(NUM_OUTPUTS - 1)) begin
                        state         <= DONE;
                        done_calc     <= 1'b1;
                        results_ready <= 1'b1;
                    end else begin
                        state          <= RUN;
                        neuron         <= neuron + 4'd1;
                        base           <= base + WADDR_W'(NUM_INPUTS);
                        pixel_address  <= '0;
                        weight_address <= base + WADDR_W'(NUM_INPUTS);
                        mem_rd_en      <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    mac_unit #(
        .DATA_W    (DATA_W),
        .ACC_W     (ACC_W),
        .FRAC_BITS (FRAC_BITS),
        .RES_W     (RES_W)
    ) u_mac (
        .clk    (clk),
        .rst    (rst),
        .clear  (acc_clear),
        .valid  (pipe_valid),
        .pixel  (pixel_q),
        .weight (weight_q),
        .result (result_output)
    );
endmodule
